// File: rtl/popcount_stream_acc_pkg.sv
// Shared types and width helper for the popcount stream accumulator.
package popcount_pkg;

    typedef enum logic [0:0] {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } state_t;

    function automatic int cnt_w(input int in_w);
        return $clog2(in_w + 1);
    endfunction

endpackage

// File: rtl/popcount_stream_acc_if.sv
// Input beat stream and output frame-total handshake of the accumulator.
// valid/ready: a transfer happens on a rising edge where valid and ready are both 1;
// the source holds its payload stable while valid is 1 and ready is 0.
interface popcount_stream_acc_if #(
    parameter int IN_W  = 15,
    parameter int ACC_W = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [IN_W-1:0]  in_data;
    logic             in_last;
    logic             out_valid;
    logic             out_ready;
    logic [ACC_W-1:0] out_count;
    logic             out_ovf;

    modport slave (
        input  in_valid, in_data, in_last, out_ready,
        output in_ready, out_valid, out_count, out_ovf
    );

    modport master (
        output in_valid, in_data, in_last, out_ready,
        input  in_ready, out_valid, out_count, out_ovf
    );
endinterface

// File: rtl/popcount_stream_acc_ones_count_n.sv
// Purely combinational population count of one input beat.
module ones_count_n
    import popcount_pkg::*;
#(
    parameter int IN_W = 15,
    localparam int CNT_W = cnt_w(IN_W)
) (
    input  logic [IN_W-1:0]  i_data,
    output logic [CNT_W-1:0] o_count
);

    always_comb begin
        o_count = '0;
        for (int i = 0; i < IN_W; i++) begin
            o_count = o_count + CNT_W'(i_data[i]);
        end
    end

endmodule

// File: rtl/popcount_stream_acc.sv
// Streams beats, popcounts each one and emits a saturating per-frame total.
// Stage 1 buffers one counted beat; the FSM holds a finished total until it is taken.
module popcount_stream_acc
    import popcount_pkg::*;
#(
    parameter int IN_W  = 15,
    parameter int ACC_W = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  beat_mode,
    input  logic                  clear,
    popcount_stream_acc_if.slave  bus,
    output state_t                o_state
);

    localparam int CNT_W = cnt_w(IN_W);
    localparam int SUM_W = ACC_W + 1;
    localparam logic [ACC_W-1:0] ACC_MAX = '1;

    state_t             r_state;
    state_t             w_next;
    logic               r_s1_valid;
    logic               r_s1_last;
    logic [CNT_W-1:0]   r_s1_pc;
    logic [CNT_W-1:0]   w_pc;
    logic [ACC_W-1:0]   r_acc;
    logic               r_acc_ovf;
    logic [ACC_W-1:0]   r_out_count;
    logic               r_out_ovf;
    logic [SUM_W-1:0]   w_sum;
    logic [ACC_W-1:0]   w_sat;
    logic               w_frame_ovf;
    logic               w_in_ready;
    logic               w_accept;
    logic               w_drain;
    logic               w_out_hs;

    ones_count_n #(.IN_W(IN_W)) u_ones (
        .i_data  (bus.in_data),
        .o_count (w_pc)
    );

    // In HOLD the stage-1 register may still take one beat, then stalls.
    assign w_in_ready = !clear && (!r_s1_valid || r_state == ACCUM);
    assign w_accept   = bus.in_valid && w_in_ready;
    assign w_drain    = (r_state == ACCUM) && r_s1_valid;
    assign w_out_hs   = (r_state == HOLD) && bus.out_ready;

    // One extra sum bit flags the carry out; once saturated the frame stays pinned at max.
    assign w_sum       = {1'b0, r_acc} + SUM_W'(r_s1_pc);
    assign w_sat       = w_sum[ACC_W] ? ACC_MAX : w_sum[ACC_W-1:0];
    assign w_frame_ovf = r_acc_ovf | w_sum[ACC_W];

    always_comb begin
        w_next = r_state;
        case (r_state)
            ACCUM:   if (w_drain && r_s1_last) w_next = HOLD;
            HOLD:    if (bus.out_ready)        w_next = ACCUM;
            default: w_next = ACCUM;
        endcase
        if (clear) w_next = ACCUM;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= ACCUM;
        else        r_state <= w_next;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_valid <= 1'b0;
            r_s1_last  <= 1'b0;
            r_s1_pc    <= '0;
        end else if (clear) begin
            r_s1_valid <= 1'b0;
        end else if (w_accept) begin
            r_s1_valid <= 1'b1;
            r_s1_last  <= bus.in_last | beat_mode;
            r_s1_pc    <= w_pc;
        end else if (w_drain) begin
            r_s1_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc       <= '0;
            r_acc_ovf   <= 1'b0;
            r_out_count <= '0;
            r_out_ovf   <= 1'b0;
        end else if (clear) begin
            r_acc     <= '0;
            r_acc_ovf <= 1'b0;
            r_out_ovf <= 1'b0;
        end else if (w_drain) begin
            if (r_s1_last) begin
                r_out_count <= w_sat;
                r_out_ovf   <= w_frame_ovf;
                r_acc       <= '0;
                r_acc_ovf   <= 1'b0;
            end else begin
                r_acc     <= w_sat;
                r_acc_ovf <= w_frame_ovf;
            end
        end else if (w_out_hs) begin
            r_out_ovf <= 1'b0;
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = (r_state == HOLD);
    assign bus.out_count = r_out_count;
    assign bus.out_ovf   = r_out_ovf;
    assign o_state       = r_state;

endmodule

// File: tb/tb_popcount_stream_acc.sv
// Bench: two accumulators (8-bit and 4-bit totals) share one stimulus stream;
// a frame-sum model feeds an expected queue that a negedge monitor drains.
module tb_popcount_stream_acc;
    import popcount_pkg::*;

    localparam int IN_W   = 15;
    localparam int WA     = 8;
    localparam int WB     = 4;
    localparam int LIMIT  = 200;

    logic clk;
    logic rst_n;
    logic tb_in_valid;
    logic [IN_W-1:0] tb_in_data;
    logic tb_in_last;
    logic tb_beat_mode;
    logic tb_clear;
    logic tb_out_ready;
    bit   rdy_rand;
    state_t sta;
    state_t stb;

    int checks = 0;
    int errors = 0;
    int frame_sum = 0;
    logic [31:0] exp_q[$];

    popcount_stream_acc_if #(.IN_W(IN_W), .ACC_W(WA)) ifa ();
    popcount_stream_acc_if #(.IN_W(IN_W), .ACC_W(WB)) ifb ();

    assign ifa.in_valid  = tb_in_valid;
    assign ifa.in_data   = tb_in_data;
    assign ifa.in_last   = tb_in_last;
    assign ifa.out_ready = tb_out_ready;
    assign ifb.in_valid  = tb_in_valid;
    assign ifb.in_data   = tb_in_data;
    assign ifb.in_last   = tb_in_last;
    assign ifb.out_ready = tb_out_ready;

    popcount_stream_acc #(.IN_W(IN_W), .ACC_W(WA)) dut_a (
        .clk(clk), .rst_n(rst_n), .beat_mode(tb_beat_mode), .clear(tb_clear),
        .bus(ifa), .o_state(sta)
    );

    popcount_stream_acc #(.IN_W(IN_W), .ACC_W(WB)) dut_b (
        .clk(clk), .rst_n(rst_n), .beat_mode(tb_beat_mode), .clear(tb_clear),
        .bus(ifb), .o_state(stb)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (rdy_rand) begin
            #1;
            tb_out_ready = 1'($urandom_range(0, 1));
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] sat_of(input logic [31:0] s, input int w);
        logic [31:0] mx;
        mx = (32'd1 << w) - 32'd1;
        return (s > mx) ? mx : s;
    endfunction

    // reference model: frame totals are plain sums of ones; clear/reset drop everything pending
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            exp_q.delete();
            frame_sum = 0;
        end else if (tb_clear) begin
            exp_q.delete();
            frame_sum = 0;
        end else if (tb_in_valid && ifa.in_ready) begin
            frame_sum += $countones(tb_in_data);
            if (tb_in_last || tb_beat_mode) begin
                exp_q.push_back(32'(frame_sum));
                frame_sum = 0;
            end
        end
    end

    // monitor / scoreboard: presented total must match the queue head every cycle it is shown
    always @(negedge clk) begin
        logic [31:0] s;
        if (rst_n) begin
            check("valid_pair", 32'(ifb.out_valid), 32'(ifa.out_valid));
            if (ifa.out_valid) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_total actual=%0d expected=none at %0t", ifa.out_count, $time);
                end else begin
                    s = exp_q[0];
                    check("count_w8", 32'(ifa.out_count), sat_of(s, WA));
                    check("ovf_w8",   32'(ifa.out_ovf),   32'(s > 32'd255));
                    check("count_w4", 32'(ifb.out_count), sat_of(s, WB));
                    check("ovf_w4",   32'(ifb.out_ovf),   32'(s > 32'd15));
                    if (tb_out_ready) void'(exp_q.pop_front());
                end
            end
        end
    end

    // driver tasks; each returns 1 ns after a rising edge
    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_accept(output int n);
        n = 0;
        @(negedge clk);
        while (!ifa.in_ready && n < LIMIT) begin
            n++;
            @(negedge clk);
        end
        if (n >= LIMIT) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout actual=%0d expected=<%0d cycles", n, LIMIT);
        end
        @(posedge clk);
        #1;
        tb_in_valid = 1'b0;
    endtask

    task automatic beat(input logic [IN_W-1:0] d, input logic last, input logic bm, output int n);
        tb_in_valid  = 1'b1;
        tb_in_data   = d;
        tb_in_last   = last;
        tb_beat_mode = bm;
        wait_accept(n);
    endtask

    task automatic clear_pulse(input logic with_beat);
        tb_clear    = 1'b1;
        tb_in_valid = with_beat;
        tb_in_data  = 15'h7FFF;
        tb_in_last  = 1'b1;
        #1;
        check("clear_ready", 32'(ifa.in_ready), 32'd0);
        @(posedge clk);
        #1;
        tb_clear    = 1'b0;
        tb_in_valid = 1'b0;
    endtask

    initial begin
        int n;
        logic [IN_W-1:0] d;
        tb_in_valid = 0; tb_in_data = '0; tb_in_last = 0; tb_beat_mode = 0;
        tb_clear = 0; tb_out_ready = 0; rdy_rand = 0;
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        check("rst_out_valid", 32'(ifa.out_valid), 32'd0);
        check("rst_out_count", 32'(ifa.out_count), 32'd0);
        check("rst_out_ovf",   32'(ifa.out_ovf),   32'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        #1;
        check("rst_in_ready", 32'(ifa.in_ready), 32'd1);
        check("rst_state",    32'(sta),          32'(ACCUM));
        idle(1);

        // single full beat: total visible right after the edge following acceptance
        tb_out_ready = 1'b1;
        beat(15'h7FFF, 1, 0, n);
        check("lat_edge0", 32'(ifa.out_valid), 32'd0);
        idle(1);
        check("lat_edge1", 32'(ifa.out_valid), 32'd1);
        idle(3);

        // back-to-back frame: 1 + 8 + 15
        beat(15'h0001, 0, 0, n); check("tput_wait0", 32'(n), 32'd0);
        beat(15'h00FF, 0, 0, n); check("tput_wait1", 32'(n), 32'd0);
        beat(15'h7FFF, 1, 0, n); check("tput_wait2", 32'(n), 32'd0);
        idle(4);

        // consumer stalls: one beat buffered, further beats refused
        tb_out_ready = 1'b0;
        beat(15'h0003, 1, 0, n);
        beat(15'h00FF, 1, 0, n);
        tb_in_valid = 1'b1; tb_in_data = 15'h0F0F; tb_in_last = 1'b1;
        repeat (5) begin
            @(negedge clk);
            check("stall_in_ready", 32'(ifa.in_ready), 32'd0);
            check("stall_state",    32'(sta),          32'(HOLD));
        end
        @(posedge clk);
        #1 tb_out_ready = 1'b1;
        wait_accept(n);
        idle(6);

        // saturation, then a fresh frame; zero-data last beat; long saturating frame
        beat(15'h7FFF, 0, 0, n);
        beat(15'h7FFF, 1, 0, n);
        beat(15'h0003, 1, 0, n);
        beat(15'h0003, 0, 0, n);
        beat(15'h0000, 1, 0, n);
        for (int i = 0; i < 20; i++) beat(15'h7FFF, 1'(i == 19), 0, n);
        idle(4);

        // beat_mode, then clear mid-frame
        beat(15'h0F0F, 0, 1, n);
        beat(15'h0001, 0, 1, n);
        idle(4);
        beat(15'h00FF, 0, 0, n);
        idle(2);
        clear_pulse(1'b1);
        beat(15'h0003, 1, 0, n);
        idle(4);

        // clear while a total is held discards it
        tb_out_ready = 1'b0;
        beat(15'h0005, 1, 0, n);
        idle(2);
        check("hold_before_clear", 32'(sta), 32'(HOLD));
        clear_pulse(1'b0);
        check("clear_hold_valid", 32'(ifa.out_valid), 32'd0);
        tb_out_ready = 1'b1;
        beat(15'h0001, 1, 0, n);
        idle(4);

        // reset in HOLD
        tb_out_ready = 1'b0;
        beat(15'h0001, 1, 0, n);
        idle(2);
        rst_n = 1'b0;
        #1;
        check("rst_hold_valid", 32'(ifa.out_valid), 32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        tb_out_ready = 1'b1;
        beat(15'h0007, 1, 0, n);
        idle(4);

        // randomized traffic with random consumer backpressure
        rdy_rand = 1'b1;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 39) == 0) begin
                clear_pulse(1'($urandom_range(0, 1)));
            end else begin
                d = ($urandom_range(0, 3) == 0) ? 15'h7FFF : IN_W'($urandom);
                beat(d, 1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 7) == 0), n);
            end
        end

        rdy_rand = 1'b0;
        #2 tb_out_ready = 1'b1;
        n = 0;
        while (exp_q.size() != 0 && n < 100) begin
            @(posedge clk);
            n++;
        end
        #1;
        check("drain_queue", 32'(exp_q.size()), 32'd0);
        idle(2);
        check("drain_idle", 32'(ifa.out_valid), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/popcount_stream_acc.md
POPCOUNT_STREAM_ACC -- requirements
Module: popcount_stream_acc

Interface
REQ-001 Parameter IN_W, default 15, number of input bits counted per beat (1..64).
REQ-002 Parameter ACC_W, default 16, frame-total width; SHALL be >= CNT_W = clog2(IN_W+1).
REQ-003 clk  input  1  single clock; all state on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 in_valid  input  1  input beat present.
REQ-006 in_ready  output  1  block accepts the beat this cycle.
REQ-007 in_data  input  IN_W  bits to count.
REQ-008 in_last  input  1  beat closes the current frame.
REQ-009 beat_mode  input  1  1: every beat is treated as last; sampled per beat.
REQ-010 clear  input  1  synchronous flush of the partial frame and the stage-1 beat.
REQ-011 out_valid  output  1  frame total present.
REQ-012 out_ready  input  1  consumer takes the total.
REQ-013 out_count  output  ACC_W  ones in the frame, saturated.
REQ-014 out_ovf  output  1  frame total saturated.

Function
REQ-015 Input handshake occurs on an edge where in_valid and in_ready are both 1; output handshake occurs where out_valid and out_ready are both 1.
REQ-016 Stage 1 registers the beat popcount (CNT_W bits), the valid bit and the last flag (in_last OR beat_mode).
REQ-017 FSM states: ACCUM, HOLD; reset state ACCUM.
REQ-018 In ACCUM with stage 1 valid: acc <= sat(acc + pc); stage 1 drains; if last, go to HOLD with out_count = sat(acc + pc), then acc <= 0.
REQ-019 sat(): a sum exceeding 2^ACC_W-1 SHALL yield 2^ACC_W-1 and set a sticky ovf flag for the frame.
REQ-020 In HOLD: out_valid = 1 and out_count/out_ovf SHALL stay stable until the output handshake; the next edge then returns to ACCUM with ovf cleared.
REQ-021 in_ready = !clear AND (!s1_valid OR state == ACCUM); stage 1 SHALL hold one beat while in HOLD.
REQ-022 Latency: when the last beat is accepted at edge E, out_valid SHALL be 1 immediately after edge E+1 (out_ready irrelevant before then).
REQ-023 Throughput: in ACCUM, one beat per cycle with no bubbles.
REQ-024 Frame boundaries: beats after a last beat SHALL count toward the next frame only.
REQ-025 clear = 1: stage 1 invalidated, acc = 0, ovf = 0, state -> ACCUM on that edge; any beat presented that cycle is not accepted; clear overrides HOLD and discards an un-handshaked total.
REQ-026 A last beat with in_data = 0 SHALL still produce a frame (out_count = acc).
REQ-027 All outputs SHALL be driven from registers or from state only; there is no combinational path from in_data to out_count.

Reset
REQ-028 rst_n low asynchronously forces: state ACCUM, s1_valid 0, acc 0, out_valid 0, out_count 0, out_ovf 0. in_ready SHALL be 1 after release unless clear is asserted.
REQ-029 Reset asserted mid-frame or in HOLD SHALL discard all partial and pending results; no frame total is emitted for them.

Structure
REQ-030 Package popcount_pkg SHALL hold the FSM state enum (ACCUM, HOLD) and the CNT_W width function.
REQ-031 Sub-module ones_count_n (parametrised IN_W, purely combinational) SHALL compute the beat popcount; popcount_stream_acc instantiates it once ahead of stage 1.

Verification
REQ-032 IN_W=15, beat 0x7FFF, in_last = 1 -> out_count = 15, out_ovf = 0, out_valid 1 after the second edge.
REQ-033 Frame 0x0001, 0x00FF, 0x7FFF (last), back-to-back, out_ready = 1 -> out_count = 24, in_ready stays 1.
REQ-034 out_ready held 0 for 5 cycles after a total with in_valid held 1 -> exactly one beat is buffered, in_ready = 0, the total is stable; the next frame's count is correct after release.
REQ-035 ACC_W=4: beats 0x7FFF, 0x7FFF (last) -> out_count = 15, out_ovf = 1; next frame 0x0003 (last) -> 2, out_ovf = 0.
REQ-036 beat_mode = 1, beats 0x0F0F, 0x0001 -> two totals, 8 then 1; clear mid-frame after 0x00FF then 0x0003 (last) -> 2.
REQ-037 rst_n pulsed low in HOLD -> out_valid falls at once; after release, frame 0x0007 (last) -> 3.
